wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 29 ++
 rtl/wb_stage_trace_fifo.sv | 57 +++++
 rtl/wb_stage.sv | 100 ++++++++++
 tb/tb_wb_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared pipeline bus layouts: mem2->wb bus, regfile-write/forward bus, commit-trace entry.
package wb_stage_pkg;

   localparam int MS_TO_WS_WD = 102;
   localparam int WS_TO_RF_WD = 38;
   localparam int TRACE_WD    = 69;

   // Field order below fixes the bit offsets: reg_we[101], dest[100:96], result[95:64], pc[63:32], inst[31:0]
   typedef struct packed {
      logic        reg_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
      logic [31:0] inst;
   } ms_to_ws_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } ws_to_rf_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } trace_t;

endpackage

// File: rtl/wb_stage_trace_fifo.sv
// Commit-trace FIFO: power-of-two depth, head visible combinationally, storage left unreset.
module trace_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 69,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_en;
   logic             pop_en;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign pop_en  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_en = push & (~full | pop_en);

   always_ff @(posedge clk) begin
      if (push_en)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_en)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_en && !pop_en)
            count_reg <= count_reg + 1'b1;
         else if (pop_en && !push_en)
            count_reg <= count_reg - 1'b1;
      end
   end

   assign pop_data = mem[rd_ptr_reg];
   assign count    = count_reg;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the mem2 result, drives regfile write/forwarding, and
// pushes each committed instruction exactly once into a buffered trace stream.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int MS_TO_WS_BUS_WD = MS_TO_WS_WD,
   parameter int WS_TO_RF_BUS_WD = WS_TO_RF_WD,
   parameter int TRACE_DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [5:0]                 stall,
   input  logic [MS_TO_WS_BUS_WD-1:0] ms2_to_ws_bus,
   output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
   output logic [WS_TO_RF_BUS_WD-1:0] ws_to_es_bus,
   output logic                       stallreq_ws,
   output logic [31:0]                debug_wb_pc,
   output logic [3:0]                 debug_wb_rf_we,
   output logic [4:0]                 debug_wb_rf_wnum,
   output logic [31:0]                debug_wb_rf_wdata,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [TRACE_WD-1:0]        trace_data
);

   localparam int CNT_W = $clog2(TRACE_DEPTH + 1);

   ms_to_ws_t        ws_reg;
   logic             pushed_reg;
   logic             ws_valid;
   logic             rf_we;
   logic             pop;
   logic             push_ok;
   logic             commit;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   ws_to_rf_t        rf_bus;
   trace_t           trace_entry;
   logic             unused_bits;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws_reg     <= '0;
         pushed_reg <= 1'b0;
      end else if (flush || (stall[4] && !stall[5])) begin
         ws_reg     <= '0;
         pushed_reg <= 1'b0;
      end else if (!stall[4]) begin
         ws_reg     <= ms2_to_ws_bus;
         pushed_reg <= 1'b0;
      end else if (commit) begin
         // Held instruction already traced; stays silent until the next load.
         pushed_reg <= 1'b1;
      end
   end

   assign ws_valid = (ws_reg.pc != 32'h0);
   assign rf_we    = ws_valid & ws_reg.reg_we & (ws_reg.dest != 5'd0);

   assign rf_bus.we    = rf_we;
   assign rf_bus.waddr = ws_reg.dest;
   assign rf_bus.wdata = ws_reg.result;
   assign ws_to_rf_bus = rf_bus;
   assign ws_to_es_bus = rf_bus;

   assign trace_valid = ~fifo_empty;
   assign pop         = trace_valid & trace_ready;
   assign push_ok     = (fifo_count < CNT_W'(TRACE_DEPTH)) | pop;
   assign commit      = ws_valid & ~pushed_reg & push_ok;
   assign stallreq_ws = ws_valid & ~pushed_reg & ~push_ok;

   assign debug_wb_pc       = ws_reg.pc;
   assign debug_wb_rf_wnum  = ws_reg.dest;
   assign debug_wb_rf_wdata = ws_reg.result;
   assign debug_wb_rf_we    = {4{rf_we & commit}};

   assign trace_entry.pc    = ws_reg.pc;
   assign trace_entry.wnum  = ws_reg.dest;
   assign trace_entry.wdata = ws_reg.result;

   trace_fifo #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (TRACE_WD)
   ) u_trace_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (commit),
      .push_data (trace_entry),
      .pop       (pop),
      .pop_data  (trace_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign unused_bits = ^{stall[3:0], ws_reg.inst, fifo_full};

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single-instruction behaviour plus
// hand-written sequences for FIFO full/backpressure, stall hold, flush and async reset.
module tb_wb_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic [5:0]   stall;
   logic [101:0] ms2_to_ws_bus;
   logic [37:0]  ws_to_rf_bus;
   logic [37:0]  ws_to_es_bus;
   logic         stallreq_ws;
   logic [31:0]  debug_wb_pc;
   logic [3:0]   debug_wb_rf_we;
   logic [4:0]   debug_wb_rf_wnum;
   logic [31:0]  debug_wb_rf_wdata;
   logic         trace_valid;
   logic         trace_ready;
   logic [68:0]  trace_data;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .stall             (stall),
      .ms2_to_ws_bus     (ms2_to_ws_bus),
      .ws_to_rf_bus      (ws_to_rf_bus),
      .ws_to_es_bus      (ws_to_es_bus),
      .stallreq_ws       (stallreq_ws),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_we    (debug_wb_rf_we),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .trace_valid       (trace_valid),
      .trace_ready       (trace_ready),
      .trace_data        (trace_data)
   );

   typedef struct {
      logic        reg_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
      logic        exp_rf_we;
      logic [3:0]  exp_dbg_we;
      logic        exp_tv;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [101:0] instr(input logic we, input logic [4:0] d,
                                          input logic [31:0] r, input logic [31:0] pc);
      return {we, d, r, pc, 32'h0000_0013};
   endfunction

   function automatic logic [68:0] entry(input logic [31:0] pc, input logic [4:0] d,
                                         input logic [31:0] r);
      return {pc, d, r};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   // Requires trace_ready=1: checks the head entry and then consumes it.
   task automatic expect_entry(input string name, input logic [68:0] exp);
      check({name, "_tv"}, trace_valid, 1'b1);
      check({name, "_data"}, trace_data, exp);
      $display("[TB] trace pop %s data=%h", name, trace_data);
      step();
   endtask

   initial begin
      int pulses;

      vecs[0] = '{1'b1, 5'd5,  32'hdeadbeef, 32'h1c000004, 1'b1, 4'hf, 1'b0};
      vecs[1] = '{1'b1, 5'd0,  32'h12345678, 32'h1c000008, 1'b0, 4'h0, 1'b1};
      vecs[2] = '{1'b0, 5'd7,  32'h00000055, 32'h1c00000c, 1'b0, 4'h0, 1'b1};
      vecs[3] = '{1'b1, 5'd3,  32'h00000099, 32'h00000000, 1'b0, 4'h0, 1'b1};
      vecs[4] = '{1'b1, 5'd31, 32'hffffffff, 32'h1c000010, 1'b1, 4'hf, 1'b0};
      vecs[5] = '{1'b1, 5'd1,  32'h00000000, 32'h1c000014, 1'b1, 4'hf, 1'b1};

      reset = 1'b1;
      flush = 1'b0;
      stall = 6'b0;
      trace_ready = 1'b0;
      ms2_to_ws_bus = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_rf_bus", ws_to_rf_bus, 38'h0);
      check("rst_es_bus", ws_to_es_bus, 38'h0);
      check("rst_dbg_pc", debug_wb_pc, 32'h0);
      check("rst_dbg_we", debug_wb_rf_we, 4'h0);
      check("rst_dbg_wnum", debug_wb_rf_wnum, 5'h0);
      check("rst_dbg_wdata", debug_wb_rf_wdata, 32'h0);
      check("rst_stallreq", stallreq_ws, 1'b0);
      check("rst_tv", trace_valid, 1'b0);

      // Table: one instruction per cycle, consumer always ready.
      trace_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ms2_to_ws_bus = instr(vecs[i].reg_we, vecs[i].dest, vecs[i].result, vecs[i].pc);
         step();
         $display("[TB] vec %0d pc=%h rf_bus=%h dbg_we=%h tv=%b", i, debug_wb_pc,
                  ws_to_rf_bus, debug_wb_rf_we, trace_valid);
         check($sformatf("vec%0d_rf_bus", i), ws_to_rf_bus,
               {vecs[i].exp_rf_we, vecs[i].dest, vecs[i].result});
         check($sformatf("vec%0d_es_bus", i), ws_to_es_bus,
               {vecs[i].exp_rf_we, vecs[i].dest, vecs[i].result});
         check($sformatf("vec%0d_dbg_pc", i), debug_wb_pc, vecs[i].pc);
         check($sformatf("vec%0d_dbg_we", i), debug_wb_rf_we, vecs[i].exp_dbg_we);
         check($sformatf("vec%0d_stallreq", i), stallreq_ws, 1'b0);
         check($sformatf("vec%0d_tv", i), trace_valid, vecs[i].exp_tv);
         if (i > 0 && vecs[i].exp_tv)
            check($sformatf("vec%0d_tdata", i), trace_data,
                  entry(vecs[i-1].pc, vecs[i-1].dest, vecs[i-1].result));
      end
      ms2_to_ws_bus = '0;
      step();
      step();
      check("tbl_drained_tv", trace_valid, 1'b0);

      // Backpressure: fill the FIFO, then release with a same-cycle push+pop.
      do_reset();
      trace_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         ms2_to_ws_bus = instr(1'b1, 5'(k + 1), 32'h100 + k, 32'h1c001000 + 4 * k);
         step();
         $display("[TB] fill %0d stallreq=%b dbg_we=%h", k, stallreq_ws, debug_wb_rf_we);
         check($sformatf("fill%0d_stallreq", k), stallreq_ws, (k == 4));
         check($sformatf("fill%0d_dbg_we", k), debug_wb_rf_we, (k == 4) ? 4'h0 : 4'hf);
      end
      stall = 6'b110000;
      trace_ready = 1'b1;
      #1;
      check("full_pop_stallreq", stallreq_ws, 1'b0);
      check("full_pop_dbg_we", debug_wb_rf_we, 4'hf);
      check("full_pop_head", trace_data, entry(32'h1c001000, 5'd1, 32'h100));
      step();
      trace_ready = 1'b0;
      #1;
      check("after_pp_tv", trace_valid, 1'b1);
      check("after_pp_head", trace_data, entry(32'h1c001004, 5'd2, 32'h101));
      check("after_pp_dbg_we", debug_wb_rf_we, 4'h0);
      check("after_pp_stallreq", stallreq_ws, 1'b0);
      stall = 6'b0;
      ms2_to_ws_bus = '0;
      trace_ready = 1'b1;
      for (int k = 1; k < 5; k++)
         expect_entry($sformatf("full_drain%0d", k),
                      entry(32'h1c001000 + 4 * k, 5'(k + 1), 32'h100 + k));
      check("full_drain_empty", trace_valid, 1'b0);

      // Stall hold: one instruction held three cycles is traced once.
      do_reset();
      trace_ready = 1'b0;
      ms2_to_ws_bus = instr(1'b1, 5'd9, 32'hcafe0009, 32'h1c002000);
      step();
      pulses = (debug_wb_rf_we == 4'hf) ? 1 : 0;
      stall = 6'b110000;
      for (int c = 0; c < 3; c++) begin
         step();
         if (debug_wb_rf_we == 4'hf)
            pulses++;
         check($sformatf("hold%0d_rf_we", c), ws_to_rf_bus[37], 1'b1);
      end
      check("hold_pulses", pulses, 1);
      stall = 6'b0;
      ms2_to_ws_bus = '0;
      step();
      trace_ready = 1'b1;
      #1;
      expect_entry("hold_entry", entry(32'h1c002000, 5'd9, 32'hcafe0009));
      check("hold_single_entry", trace_valid, 1'b0);

      // Flush with two entries queued: register clears, FIFO drains in order.
      do_reset();
      trace_ready = 1'b0;
      ms2_to_ws_bus = instr(1'b1, 5'd10, 32'h0000aaaa, 32'h1c003000);
      step();
      ms2_to_ws_bus = instr(1'b1, 5'd11, 32'h0000bbbb, 32'h1c003004);
      step();
      flush = 1'b1;
      ms2_to_ws_bus = instr(1'b1, 5'd12, 32'h0000cccc, 32'h1c003008);
      step();
      flush = 1'b0;
      ms2_to_ws_bus = '0;
      check("flush_rf_bus", ws_to_rf_bus, 38'h0);
      check("flush_dbg_we", debug_wb_rf_we, 4'h0);
      check("flush_dbg_pc", debug_wb_pc, 32'h0);
      trace_ready = 1'b1;
      #1;
      expect_entry("flush_e0", entry(32'h1c003000, 5'd10, 32'h0000aaaa));
      expect_entry("flush_e1", entry(32'h1c003004, 5'd11, 32'h0000bbbb));
      check("flush_empty", trace_valid, 1'b0);

      // Asynchronous reset mid-cycle with three queued entries.
      do_reset();
      trace_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ms2_to_ws_bus = instr(1'b1, 5'(k + 20), 32'h200 + k, 32'h1c004000 + 4 * k);
         step();
      end
      check("pre_arst_tv", trace_valid, 1'b1);
      check("pre_arst_rf_we", ws_to_rf_bus[37], 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_tv", trace_valid, 1'b0);
      check("arst_rf_bus", ws_to_rf_bus, 38'h0);
      check("arst_dbg_we", debug_wb_rf_we, 4'h0);
      check("arst_stallreq", stallreq_ws, 1'b0);
      check("arst_dbg_pc", debug_wb_pc, 32'h0);
      #1;
      reset = 1'b0;
      ms2_to_ws_bus = '0;
      step();
      check("post_arst_tv", trace_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
